// File: rtl/input_pkg.sv
// Shared types and constants for the arcade input conditioner: coin FSM states, PS/2 scancodes, joystick bits.
// Latency: n/a (package only).
// Backpressure: none; all inputs are level or toggle signalled.
package input_pkg;

    typedef enum logic [1:0] {
        COIN_IDLE    = 2'd0,
        COIN_ACTIVE  = 2'd1,
        COIN_LOCKOUT = 2'd2
    } coin_state_e;

    // Arrow keys are matched on the low 8 bits so the extended flag is ignored.
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [8:0] SC_FIRE_A   = 9'h029;
    localparam logic [8:0] SC_FIRE_B   = 9'h014;
    localparam logic [8:0] SC_START1_A = 9'h005;
    localparam logic [8:0] SC_START1_B = 9'h016;
    localparam logic [8:0] SC_START2_A = 9'h006;
    localparam logic [8:0] SC_START2_B = 9'h01E;
    localparam logic [8:0] SC_COIN_A   = 9'h02E;
    localparam logic [8:0] SC_COIN_B   = 9'h036;
    localparam logic [8:0] SC_P2_UP    = 9'h02D;
    localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
    localparam logic [8:0] SC_P2_LEFT  = 9'h023;
    localparam logic [8:0] SC_P2_RIGHT = 9'h034;
    localparam logic [8:0] SC_P2_FIRE  = 9'h01C;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;
    localparam int JOY_COIN   = 7;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic fire;
    } player_t;

    typedef struct packed {
        player_t p1;
        player_t p2;
        logic    start1;
        logic    start2;
        logic    coin;
    } keys_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bundles the raw PS/2 + joystick inputs and the conditioned control outputs.
// Latency: n/a (wiring only).
// Backpressure: none.
interface input_conditioner_if;

    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        no_rotate;

    logic up1;
    logic down1;
    logic left1;
    logic right1;
    logic fire1;
    logic up2;
    logic down2;
    logic left2;
    logic right2;
    logic fire2;
    logic start1;
    logic start2;
    logic coin1;

    modport master (
        output ps2_key, joystick_0, joystick_1, no_rotate,
        input  up1, down1, left1, right1, fire1,
        input  up2, down2, left2, right2, fire2,
        input  start1, start2, coin1
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, no_rotate,
        output up1, down1, left1, right1, fire1,
        output up2, down2, left2, right2, fire2,
        output start1, start2, coin1
    );

endinterface

// File: rtl/input_conditioner_coin_pulser.sv
// Turns each accepted rising edge of the coin request into a COIN_HI-cycle pulse followed by a COIN_LO-cycle lockout.
// Latency: coin1 rises one cycle after the edge is seen; registered output.
// Backpressure: none; edges arriving while busy are dropped.
module coin_pulser
    import input_pkg::*;
#(
    parameter int COIN_HI = 1200000,
    parameter int COIN_LO = 1200000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic coin_req,
    output logic coin1
);

    localparam int CNT_MAX = max_int(COIN_HI, COIN_LO);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(COIN_HI - 1);
    localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(COIN_LO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    coin_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             coin_req_q, coin_req_d;
    logic             coin1_q, coin1_d;
    logic             req_rise;

    always_comb begin
        coin_req_d = coin_req;
        req_rise   = coin_req & ~coin_req_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        coin1_d    = 1'b0;
        case (state_q)
            COIN_IDLE: begin
                if (req_rise) begin
                    state_d = COIN_ACTIVE;
                    cnt_d   = HI_LOAD;
                    coin1_d = 1'b1;
                end
            end
            COIN_ACTIVE: begin
                if (cnt_q == '0) begin
                    state_d = COIN_LOCKOUT;
                    cnt_d   = LO_LOAD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    coin1_d = 1'b1;
                end
            end
            COIN_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = COIN_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = COIN_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The request copy tracks the live input during reset so release cannot fake an edge.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= COIN_IDLE;
            cnt_q      <= '0;
            coin_req_q <= coin_req;
            coin1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            coin_req_q <= coin_req_d;
            coin1_q    <= coin1_d;
        end
    end

    assign coin1 = coin1_q;

endmodule

// File: rtl/input_conditioner.sv
// Decodes PS/2 key events into latched keys, merges joysticks, applies rotation and drives registered controls.
// Latency: 1 cycle from joystick, 2 cycles from a PS/2 toggle; coin1 via coin_pulser.
// Backpressure: none; every toggle of ps2_key[10] is consumed in the cycle it appears.
module input_conditioner
    import input_pkg::*;
#(
    parameter int COIN_HI = 1200000,
    parameter int COIN_LO = 1200000
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input_conditioner_if.slave   io
);

    logic        toggle_q, toggle_d;
    keys_t       keys_q, keys_d;
    player_t     p1_q, p1_d;
    player_t     p2_q, p2_d;
    logic        start1_q, start1_d;
    logic        start2_q, start2_d;

    logic [15:0] joy;
    logic        joy_unused;
    logic [8:0]  code;
    logic        pressed;
    logic        key_event;
    player_t     p1_in;
    logic        coin_req;
    logic        coin1;

    always_comb begin
        toggle_d  = io.ps2_key[10];
        key_event = io.ps2_key[10] != toggle_q;
        pressed   = io.ps2_key[9];
        code      = io.ps2_key[8:0];
        keys_d    = keys_q;
        if (key_event) begin
            case (code)
                {1'b0, SC_UP},    {1'b1, SC_UP}:    keys_d.p1.up    = pressed;
                {1'b0, SC_DOWN},  {1'b1, SC_DOWN}:  keys_d.p1.down  = pressed;
                {1'b0, SC_LEFT},  {1'b1, SC_LEFT}:  keys_d.p1.left  = pressed;
                {1'b0, SC_RIGHT}, {1'b1, SC_RIGHT}: keys_d.p1.right = pressed;
                SC_FIRE_A,   SC_FIRE_B:             keys_d.p1.fire  = pressed;
                SC_START1_A, SC_START1_B:           keys_d.start1   = pressed;
                SC_START2_A, SC_START2_B:           keys_d.start2   = pressed;
                SC_COIN_A,   SC_COIN_B:             keys_d.coin     = pressed;
                SC_P2_UP:                           keys_d.p2.up    = pressed;
                SC_P2_DOWN:                         keys_d.p2.down  = pressed;
                SC_P2_LEFT:                         keys_d.p2.left  = pressed;
                SC_P2_RIGHT:                        keys_d.p2.right = pressed;
                SC_P2_FIRE:                         keys_d.p2.fire  = pressed;
                default: ;
            endcase
        end
    end

    always_comb begin
        joy         = io.joystick_0 | io.joystick_1;
        joy_unused  = ^joy[15:8];
        p1_in.up    = keys_q.p1.up    | joy[JOY_UP];
        p1_in.down  = keys_q.p1.down  | joy[JOY_DOWN];
        p1_in.left  = keys_q.p1.left  | joy[JOY_LEFT];
        p1_in.right = keys_q.p1.right | joy[JOY_RIGHT];
        p1_in.fire  = keys_q.p1.fire  | joy[JOY_FIRE];
        start1_d    = keys_q.start1   | joy[JOY_START1];
        start2_d    = keys_q.start2   | joy[JOY_START2];
        coin_req    = keys_q.coin     | joy[JOY_COIN];
        p2_d        = keys_q.p2;
        p1_d        = p1_in;
        // Horizontal cabinet: the screen is turned, so player-1 directions rotate.
        if (io.no_rotate) begin
            p1_d.up    = p1_in.left;
            p1_d.down  = p1_in.right;
            p1_d.left  = p1_in.down;
            p1_d.right = p1_in.up;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            toggle_q <= io.ps2_key[10];
            keys_q   <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            start1_q <= 1'b0;
            start2_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
            keys_q   <= keys_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            start1_q <= start1_d;
            start2_q <= start2_d;
        end
    end

    coin_pulser #(
        .COIN_HI (COIN_HI),
        .COIN_LO (COIN_LO)
    ) u_coin_pulser (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .coin_req (coin_req),
        .coin1    (coin1)
    );

    assign io.up1    = p1_q.up;
    assign io.down1  = p1_q.down;
    assign io.left1  = p1_q.left;
    assign io.right1 = p1_q.right;
    assign io.fire1  = p1_q.fire;
    assign io.up2    = p2_q.up;
    assign io.down2  = p2_q.down;
    assign io.left2  = p2_q.left;
    assign io.right2 = p2_q.right;
    assign io.fire2  = p2_q.fire;
    assign io.start1 = start1_q;
    assign io.start2 = start2_q;
    assign io.coin1  = coin1;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with COIN_HI=4, COIN_LO=3.
// Output vector bit order: up1 down1 left1 right1 fire1 up2 down2 left2 right2 fire2 start1 start2 coin1.
module tb_input_conditioner;

    logic clk_sys = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    input_conditioner_if ifc();

    input_conditioner #(
        .COIN_HI (4),
        .COIN_LO (3)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .io      (ifc.slave)
    );

    always #5 clk_sys = ~clk_sys;

    logic [12:0] outs;
    assign outs = {ifc.up1, ifc.down1, ifc.left1, ifc.right1, ifc.fire1,
                   ifc.up2, ifc.down2, ifc.left2, ifc.right2, ifc.fire2,
                   ifc.start1, ifc.start2, ifc.coin1};

    localparam int NKEYS = 14;
    localparam logic [8:0] KEY_CODES [NKEYS] = '{
        9'h029, 9'h014, 9'h005, 9'h016, 9'h006, 9'h01E, 9'h072,
        9'h06B, 9'h174, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C};
    localparam logic [12:0] KEY_OUTS [NKEYS] = '{
        13'h0100, 13'h0100, 13'h0004, 13'h0004, 13'h0002, 13'h0002, 13'h0800,
        13'h0400, 13'h0200, 13'h0080, 13'h0040, 13'h0020, 13'h0010, 13'h0008};

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic pressed, input logic [8:0] code);
        ifc.ps2_key = {~ifc.ps2_key[10], pressed, code};
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if (outs !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", outs, 13'h0);
        end
        reset_n = 1'b1;
        step();
        step();
        checks++;
        if (outs !== 13'h0) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", outs, 13'h0);
        end
    endtask

    task automatic test_key_up();
        send_key(1'b1, 9'h075);
        checks++;
        if (ifc.up1 !== 1'b0) begin
            failures++;
            $display("FAIL key_up_latency: up1=%b expected 0", ifc.up1);
        end
        step();
        checks++;
        if (outs !== 13'h1000) begin
            failures++;
            $display("FAIL key_up_press: got %h expected %h", outs, 13'h1000);
        end
        send_key(1'b0, 9'h075);
        step();
        checks++;
        if (outs !== 13'h0) begin
            failures++;
            $display("FAIL key_up_release: got %h expected %h", outs, 13'h0);
        end
        send_key(1'b1, 9'h175);
        step();
        checks++;
        if (outs !== 13'h1000) begin
            failures++;
            $display("FAIL key_up_extended: got %h expected %h", outs, 13'h1000);
        end
        send_key(1'b0, 9'h175);
        step();
        checks++;
        if (outs !== 13'h0) begin
            failures++;
            $display("FAIL key_up_ext_release: got %h expected %h", outs, 13'h0);
        end
    endtask

    task automatic test_key_table();
        for (int k = 0; k < NKEYS; k++) begin
            send_key(1'b1, KEY_CODES[k]);
            step();
            checks++;
            if (outs !== KEY_OUTS[k]) begin
                failures++;
                $display("FAIL key_table_press code=%h: got %h expected %h", KEY_CODES[k], outs, KEY_OUTS[k]);
            end
            send_key(1'b0, KEY_CODES[k]);
            step();
            checks++;
            if (outs !== 13'h0) begin
                failures++;
                $display("FAIL key_table_release code=%h: got %h expected %h", KEY_CODES[k], outs, 13'h0);
            end
        end
    endtask

    task automatic test_coin_keys();
        logic [8:0] coin_codes [2];
        coin_codes[0] = 9'h02E;
        coin_codes[1] = 9'h036;
        for (int k = 0; k < 2; k++) begin
            send_key(1'b1, coin_codes[k]);
            step();
            checks++;
            if (outs !== 13'h0001) begin
                failures++;
                $display("FAIL coin_key_press code=%h: got %h expected %h", coin_codes[k], outs, 13'h0001);
            end
            send_key(1'b0, coin_codes[k]);
            repeat (10) step();
            checks++;
            if (outs !== 13'h0) begin
                failures++;
                $display("FAIL coin_key_done code=%h: got %h expected %h", coin_codes[k], outs, 13'h0);
            end
        end
    endtask

    task automatic test_rotate();
        logic [15:0] joy_in [6];
        logic        rot_in [6];
        logic [12:0] exp_out [6];
        joy_in[0] = 16'h0002; rot_in[0] = 1'b1; exp_out[0] = 13'h1000;
        joy_in[1] = 16'h0002; rot_in[1] = 1'b0; exp_out[1] = 13'h0400;
        joy_in[2] = 16'h0008; rot_in[2] = 1'b1; exp_out[2] = 13'h0200;
        joy_in[3] = 16'h0001; rot_in[3] = 1'b1; exp_out[3] = 13'h0800;
        joy_in[4] = 16'h0004; rot_in[4] = 1'b1; exp_out[4] = 13'h0400;
        joy_in[5] = 16'h0000; rot_in[5] = 1'b0; exp_out[5] = 13'h0000;
        for (int k = 0; k < 6; k++) begin
            ifc.joystick_0 = joy_in[k];
            ifc.no_rotate  = rot_in[k];
            step();
            checks++;
            if (outs !== exp_out[k]) begin
                failures++;
                $display("FAIL rotate[%0d] joy=%h rot=%b: got %h expected %h", k, joy_in[k], rot_in[k], outs, exp_out[k]);
            end
        end
        ifc.joystick_1 = 16'h0070;
        step();
        checks++;
        if (outs !== 13'h0106) begin
            failures++;
            $display("FAIL joy1_buttons: got %h expected %h", outs, 13'h0106);
        end
        ifc.joystick_1 = 16'h0000;
        ifc.no_rotate  = 1'b1;
        send_key(1'b1, 9'h02D);
        step();
        checks++;
        if (outs !== 13'h0080) begin
            failures++;
            $display("FAIL p2_not_rotated: got %h expected %h", outs, 13'h0080);
        end
        ifc.no_rotate = 1'b0;
        send_key(1'b0, 9'h02D);
        step();
    endtask

    task automatic test_unlisted();
        send_key(1'b1, 9'h02D);
        step();
        send_key(1'b1, 9'h01F);
        checks++;
        if (outs !== 13'h0080) begin
            failures++;
            $display("FAIL unlisted_press_a: got %h expected %h", outs, 13'h0080);
        end
        step();
        checks++;
        if (outs !== 13'h0080) begin
            failures++;
            $display("FAIL unlisted_press_b: got %h expected %h", outs, 13'h0080);
        end
        send_key(1'b0, 9'h01F);
        step();
        checks++;
        if (outs !== 13'h0080) begin
            failures++;
            $display("FAIL unlisted_release: got %h expected %h", outs, 13'h0080);
        end
        send_key(1'b0, 9'h02D);
        step();
    endtask

    task automatic test_simultaneous();
        ifc.ps2_key    = {~ifc.ps2_key[10], 1'b1, 9'h029};
        ifc.joystick_0 = 16'h0008;
        step();
        checks++;
        if (outs !== 13'h1000) begin
            failures++;
            $display("FAIL simul_cycle1: got %h expected %h", outs, 13'h1000);
        end
        step();
        checks++;
        if (outs !== 13'h1100) begin
            failures++;
            $display("FAIL simul_cycle2: got %h expected %h", outs, 13'h1100);
        end
        ifc.ps2_key    = {~ifc.ps2_key[10], 1'b0, 9'h029};
        ifc.joystick_0 = 16'h0000;
        step();
        checks++;
        if (outs !== 13'h0100) begin
            failures++;
            $display("FAIL simul_release1: got %h expected %h", outs, 13'h0100);
        end
        step();
        checks++;
        if (outs !== 13'h0) begin
            failures++;
            $display("FAIL simul_release2: got %h expected %h", outs, 13'h0);
        end
    endtask

    task automatic test_coin_pulse();
        logic [31:0] pat;
        logic [31:0] exp_c;
        pat   = 32'h0000_0001;
        exp_c = 32'h0000_000F;
        for (int i = 0; i < 12; i++) begin
            ifc.joystick_1 = pat[i] ? 16'h0080 : 16'h0000;
            step();
            checks++;
            if (ifc.coin1 !== exp_c[i]) begin
                failures++;
                $display("FAIL coin_pulse[%0d]: coin1=%b expected %b", i, ifc.coin1, exp_c[i]);
            end
        end
    endtask

    task automatic test_coin_ignore();
        logic [31:0] pat;
        logic [31:0] exp_c;
        pat   = 32'h0000_0025;
        exp_c = 32'h0000_000F;
        for (int i = 0; i < 12; i++) begin
            ifc.joystick_1 = pat[i] ? 16'h0080 : 16'h0000;
            step();
            checks++;
            if (ifc.coin1 !== exp_c[i]) begin
                failures++;
                $display("FAIL coin_ignore[%0d]: coin1=%b expected %b", i, ifc.coin1, exp_c[i]);
            end
        end
    endtask

    task automatic test_coin_hold();
        logic [31:0] pat;
        logic [31:0] exp_c;
        pat   = 32'h000F_EFFF;
        exp_c = 32'h0001_E00F;
        for (int i = 0; i < 24; i++) begin
            ifc.joystick_1 = pat[i] ? 16'h0080 : 16'h0000;
            step();
            checks++;
            if (ifc.coin1 !== exp_c[i]) begin
                failures++;
                $display("FAIL coin_hold[%0d]: coin1=%b expected %b", i, ifc.coin1, exp_c[i]);
            end
        end
    endtask

    task automatic test_coin_reset();
        send_key(1'b1, 9'h02D);
        ifc.joystick_1 = 16'h0080;
        step();
        checks++;
        if (outs !== 13'h0081) begin
            failures++;
            $display("FAIL coin_reset_first: got %h expected %h", outs, 13'h0081);
        end
        step();
        checks++;
        if (ifc.coin1 !== 1'b1) begin
            failures++;
            $display("FAIL coin_reset_second: coin1=%b expected 1", ifc.coin1);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if (outs !== 13'h0) begin
            failures++;
            $display("FAIL coin_reset_drop: got %h expected %h", outs, 13'h0);
        end
        ifc.ps2_key = {~ifc.ps2_key[10], 1'b1, 9'h075};
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (outs !== 13'h0) begin
                failures++;
                $display("FAIL coin_reset_after[%0d]: got %h expected %h", i, outs, 13'h0);
            end
        end
        ifc.joystick_1 = 16'h0000;
        step();
    endtask

    initial begin
        reset_n        = 1'b0;
        ifc.ps2_key    = 11'h0;
        ifc.joystick_0 = 16'h0;
        ifc.joystick_1 = 16'h0;
        ifc.no_rotate  = 1'b0;
        test_reset();
        test_key_up();
        test_key_table();
        test_coin_keys();
        test_rotate();
        test_unlisted();
        test_simultaneous();
        test_coin_pulse();
        test_coin_ignore();
        test_coin_hold();
        test_coin_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter COIN_HI, default 1200000, coin1 active time in clk_sys cycles (100 ms at 12 MHz); legal range >= 1.
REQ-002 Parameter COIN_LO, default 1200000, post-pulse lockout in clk_sys cycles; legal range >= 1.
REQ-003 clk_sys  in  1  system clock (12 MHz); all logic on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 ps2_key  in  11  [10] toggle strobe, [9] pressed, [8:0] scancode (extended flag in [8]).
REQ-006 joystick_0, joystick_1  in  16 each  bit map: 0 right, 1 left, 2 down, 3 up, 4 fire, 5 start1, 6 start2, 7 coin.
REQ-007 no_rotate  in  1  1 = horizontal orientation, remap directions.
REQ-008 up1, down1, left1, right1, fire1  out  1 each  player-1 controls, active high.
REQ-009 up2, down2, left2, right2, fire2  out  1 each  player-2 controls, active high.
REQ-010 start1, start2  out  1 each  start buttons, active high.
REQ-011 coin1  out  1  conditioned coin pulse, active high.

Function
REQ-012 ps2_key[10] shall be registered once per cycle; a key event is a cycle where ps2_key[10] differs from its registered value.
REQ-013 On a key event, the matching key latch shall load ps2_key[9]; unmatched codes shall change nothing.
REQ-014 Key table: up X75, down X72, left X6B, right X74 (extended bit ignored); fire 029 or 014; start1 005 or 016; start2 006 or 01E; coin 02E or 036; P2 up 02D, down 02B, left 023, right 034, fire 01C.
REQ-015 joy = joystick_0 | joystick_1; each logical input = key latch OR corresponding joy bit.
REQ-016 With no_rotate=1, P1 outputs: up=left_in, down=right_in, left=down_in, right=up_in; with no_rotate=0, straight mapping; P2 is never remapped.
REQ-017 All control outputs except coin1 shall be registered: 1-cycle latency from joystick change, 2-cycle latency from ps2_key toggle.
REQ-018 Coin FSM states: IDLE, ACTIVE, LOCKOUT; coin_req = coin key latch | joy[7]; rising edge of coin_req is detected against a registered copy.
REQ-019 IDLE: coin1=0; rising edge -> ACTIVE with counter loaded to COIN_HI-1.
REQ-020 ACTIVE: coin1=1, counter decrements; at 0 -> LOCKOUT with counter loaded to COIN_LO-1.
REQ-021 LOCKOUT: coin1=0, counter decrements; at 0 -> IDLE.
REQ-022 Rising edges during ACTIVE or LOCKOUT shall be ignored; a request still held on return to IDLE shall not retrigger (edge-only).
REQ-023 coin1 shall be a registered FSM output: first high cycle is the cycle after the edge is detected; exactly COIN_HI consecutive high cycles per accepted edge.
REQ-024 Counter width = $clog2(max(COIN_HI, COIN_LO)); no wrap shall occur.
REQ-025 Simultaneous key event and joystick change in one cycle shall both take effect in that same cycle.

Reset
REQ-026 reset_n=0 at a clock edge: all key latches 0, all outputs 0, FSM to IDLE, counter 0, registered ps2_key[10] and coin_req copies loaded from current inputs (no spurious event or edge at release).
REQ-027 Reset asserted mid-pulse shall drop coin1 to 0 at the next edge and abandon the pulse.

Structure
REQ-028 Shared package input_pkg shall hold the coin state enum, scancode constants and joystick bit-index constants.
REQ-029 Coin FSM shall be one sub-module, coin_pulser, parameterised by COIN_HI/COIN_LO; PS/2 decode and mapping stay in the top.

Verification (COIN_HI=4, COIN_LO=3 unless stated)
REQ-030 Toggle ps2_key[10] with {pressed=1, code 075} -> up1=1 two cycles later; repeat with pressed=0 -> up1=0.
REQ-031 no_rotate=1, joystick_0=0x0002 (left) -> up1=1, left1=0 next cycle; no_rotate=0 -> left1=1.
REQ-032 joystick_1 bit7 pulse for 1 cycle -> coin1 high exactly 4 cycles, low for the following 3 cycles minimum.
REQ-033 Second coin edge during ACTIVE and during LOCKOUT -> no extra pulse; coin held through return to IDLE -> no retrigger; release then re-press -> new 4-cycle pulse.
REQ-034 Assert reset_n=0 at 2nd cycle of coin pulse -> coin1=0 next cycle; after release with coin input held -> no pulse.
REQ-035 Key event with unlisted code 0x1F -> all outputs unchanged.
